// File: rtl/psx_pkg.sv
// Shared constants, state encodings and TX byte lookup for the PSX poll master.
package psx_pkg;

  localparam logic [7:0] PSX_CMD_START = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL  = 8'h42;
  localparam logic [7:0] PSX_CMD_IDLE  = 8'h00;
  localparam logic [7:0] PSX_READY     = 8'h5A;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_TIMEOUT   = 2'd1,
    ERR_NOT_READY = 2'd2
  } psx_err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATT_SETUP,
    ST_XFER,
    ST_ACK_WAIT,
    ST_GAP,
    ST_ATT_HOLD,
    ST_FINISH
  } psx_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_LO,
    PH_HI
  } psx_phase_e;

  function automatic logic [7:0] psx_tx_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return PSX_CMD_START;
      3'd1:    return PSX_CMD_POLL;
      default: return PSX_CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// One-byte PSX shifter: generates psx_clk/cmd for eight bits, samples data on
// the last cycle of each high phase and pulses done on the final sample.
module psx_byte_xfer
  import psx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       data_s,
  output logic       psx_clk,
  output logic       cmd,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

  psx_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             psx_clk_q, psx_clk_d;
  logic             cmd_q, cmd_d;
  logic             half_end;

  always_comb begin
    phase_d   = phase_q;
    half_d    = half_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    psx_clk_d = psx_clk_q;
    cmd_d     = cmd_q;
    done      = 1'b0;
    half_end  = (half_q == HALF_LAST);

    case (phase_q)
      PH_IDLE: begin
        psx_clk_d = 1'b1;
        cmd_d     = 1'b1;
      end
      PH_LO: begin
        if (half_end) begin
          phase_d   = PH_HI;
          half_d    = '0;
          psx_clk_d = 1'b1;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      PH_HI: begin
        if (half_end) begin
          rx_d   = {data_s, rx_q[7:1]};
          half_d = '0;
          if (bit_q == 3'd7) begin
            phase_d = PH_IDLE;
            cmd_d   = 1'b1;
            done    = 1'b1;
          end else begin
            phase_d   = PH_LO;
            bit_d     = bit_q + 3'd1;
            tx_d      = {1'b1, tx_q[7:1]};
            cmd_d     = tx_q[1];
            psx_clk_d = 1'b0;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase

    if (load) begin
      phase_d   = PH_LO;
      half_d    = '0;
      bit_d     = '0;
      tx_d      = tx_byte;
      cmd_d     = tx_byte[0];
      psx_clk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '1;
      rx_q      <= '0;
      psx_clk_q <= 1'b1;
      cmd_q     <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      psx_clk_q <= psx_clk_d;
      cmd_q     <= cmd_d;
    end
  end

  // rx_byte carries the just-completed byte in the same cycle done is high.
  assign rx_byte = rx_d;
  assign psx_clk = psx_clk_q;
  assign cmd     = cmd_q;

endmodule

// File: rtl/psx_poll_master.sv
// Console-side PSX controller poll master: sequences att, byte transfers,
// ack pacing and result capture for one poll per start.
module psx_poll_master
  import psx_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned ATT_SETUP   = 16,
  parameter int unsigned ACK_TIMEOUT = 400,
  parameter int unsigned BYTE_GAP    = 8,
  parameter int unsigned ATT_HOLD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        data,
  input  logic        ack,
  output logic        att,
  output logic        psx_clk,
  output logic        cmd,
  output logic        busy,
  output logic        valid,
  output logic [1:0]  err,
  output logic [7:0]  ctrl_id,
  output logic [15:0] buttons
);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(ATT_SETUP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(ATT_HOLD - 1);

  psx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       id_q, id_d;
  logic [7:0]       btn_lo_q, btn_lo_d;
  logic [7:0]       btn_hi_q, btn_hi_d;
  psx_err_e         err_q, err_d;
  logic [7:0]       ctrl_id_q, ctrl_id_d;
  logic [15:0]      buttons_q, buttons_d;
  logic             att_q, att_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic data_m_q, data_s_q, ack_m_q, ack_s_q;

  logic       load;
  logic       done;
  logic [7:0] rx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_m_q <= 1'b1;
      data_s_q <= 1'b1;
      ack_m_q  <= 1'b1;
      ack_s_q  <= 1'b1;
    end else begin
      data_m_q <= data;
      data_s_q <= data_m_q;
      ack_m_q  <= ack;
      ack_s_q  <= ack_m_q;
    end
  end

  psx_byte_xfer #(
    .CLK_DIV(CLK_DIV)
  ) u_xfer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .tx_byte(psx_tx_byte(byte_q)),
    .data_s (data_s_q),
    .psx_clk(psx_clk),
    .cmd    (cmd),
    .done   (done),
    .rx_byte(rx_byte)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    id_d      = id_q;
    btn_lo_d  = btn_lo_q;
    btn_hi_d  = btn_hi_q;
    err_d     = err_q;
    ctrl_id_d = ctrl_id_q;
    buttons_d = buttons_q;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ATT_SETUP;
          cnt_d   = '0;
          byte_d  = '0;
          err_d   = ERR_OK;
        end
      end
      ST_ATT_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_XFER;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (done) begin
          cnt_d = '0;
          if (byte_q == 3'd1) id_d = rx_byte;
          if (byte_q == 3'd3) btn_lo_d = rx_byte;
          if (byte_q == 3'd4) begin
            btn_hi_d = rx_byte;
            state_d  = ST_ATT_HOLD;
          end else if (byte_q == 3'd2 && rx_byte != PSX_READY) begin
            state_d = ST_FINISH;
            err_d   = ERR_NOT_READY;
          end else begin
            state_d = ST_ACK_WAIT;
            byte_d  = byte_q + 3'd1;
          end
        end
      end
      ST_ACK_WAIT: begin
        if (!ack_s_q) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_FINISH;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_XFER;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ATT_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d   = ST_FINISH;
          ctrl_id_d = id_q;
          buttons_d = {btn_hi_q, btn_lo_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Pin-facing strobes are registered from the next state so they move on the state edge.
    att_d   = (state_d == ST_IDLE) || (state_d == ST_FINISH);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      byte_q    <= '0;
      id_q      <= '0;
      btn_lo_q  <= '1;
      btn_hi_q  <= '1;
      err_q     <= ERR_OK;
      ctrl_id_q <= '0;
      buttons_q <= '1;
      att_q     <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      id_q      <= id_d;
      btn_lo_q  <= btn_lo_d;
      btn_hi_q  <= btn_hi_d;
      err_q     <= err_d;
      ctrl_id_q <= ctrl_id_d;
      buttons_q <= buttons_d;
      att_q     <= att_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign att     = att_q;
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign ctrl_id = ctrl_id_q;
  assign buttons = buttons_q;

endmodule

// File: tb/tb_psx_poll_master.sv
// Bench for psx_poll_master: behavioural controller responder plus a
// transaction-level model of result, byte count and poll duration.
module tb_psx_poll_master;

  localparam int C  = 8;
  localparam int AS = 16;
  localparam int AT = 400;
  localparam int BG = 8;
  localparam int AH = 16;

  logic        clk = 1'b0;
  logic        rst, start, data, ack;
  logic        att, psx_clk, cmd, busy, valid;
  logic [1:0]  err;
  logic [7:0]  ctrl_id;
  logic [15:0] buttons;

  psx_poll_master #(
    .CLK_DIV    (C),
    .ATT_SETUP  (AS),
    .ACK_TIMEOUT(AT),
    .BYTE_GAP   (BG),
    .ATT_HOLD   (AH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .ack    (ack),
    .att    (att),
    .psx_clk(psx_clk),
    .cmd    (cmd),
    .busy   (busy),
    .valid  (valid),
    .err    (err),
    .ctrl_id(ctrl_id),
    .buttons(buttons)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder state
  logic [7:0] resp   [5];
  logic [7:0] cmd_rx [5];
  int         ack_d  [4];
  bit         ack_en;
  int         ack_len;
  int         rb, rbit;

  initial begin
    bit         prev_att, prev_pclk;
    int         ack_timer, ack_low;
    logic [7:0] cur;
    data = 1'b1; ack = 1'b1;
    prev_att = 1'b1; prev_pclk = 1'b1;
    ack_timer = 0; ack_low = 0; rb = 0; rbit = 0;
    forever begin
      @(negedge clk);
      if (prev_att && !att) begin rb = 0; rbit = 0; end
      if (att !== 1'b0) begin
        data = 1'b1; ack = 1'b1; ack_timer = 0; ack_low = 0;
      end else begin
        if (ack_timer > 0) begin
          ack_timer--;
          if (ack_timer == 0) begin ack = 1'b0; ack_low = ack_len; end
        end else if (ack_low > 0) begin
          ack_low--;
          if (ack_low == 0) ack = 1'b1;
        end
        if (prev_pclk && !psx_clk && rb < 5) begin
          cur  = resp[rb];
          data = cur[rbit];
        end
        if (!prev_pclk && psx_clk && rb < 5) begin
          cur       = cmd_rx[rb];
          cur[rbit] = cmd;
          cmd_rx[rb] = cur;
          if (rbit == 7) begin
            rbit = 0;
            if (ack_en && rb < 4) ack_timer = ack_d[rb];
            rb++;
          end else begin
            rbit++;
          end
        end
      end
      prev_att  = (att === 1'b1);
      prev_pclk = (psx_clk === 1'b1);
    end
  end

  int n_valid = 0, n_att_fall = 0;
  initial begin
    bit pa;
    pa = 1'b1;
    forever begin
      @(negedge clk);
      if (pa && att === 1'b0) n_att_fall++;
      if (valid === 1'b1) n_valid++;
      pa = (att !== 1'b0);
    end
  end

  logic [15:0] exp_buttons = 16'hFFFF;
  logic [7:0]  exp_id      = 8'h00;

  task automatic set_resp(input logic [7:0] b0, b1, b2, b3, b4);
    resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3; resp[4] = b4;
  endtask

  task automatic run_poll(input string tag, input int poke);
    int         s_cyc, v_cyc, base_valid, base_fall, e_err, e_rb, e_len, tol, got_len, lnk;
    int         v_rb;
    bit         seen;
    logic [1:0] v_err;
    logic [7:0] v_id, e_cmd;
    logic [15:0] v_btn;
    logic       v_att;
    for (int k = 0; k < 4; k++) ack_d[k] = C + $urandom_range(0, 30);
    ack_len = $urandom_range(2, 4);
    for (int k = 0; k < 5; k++) cmd_rx[k] = 8'h00;

    lnk = 0;
    if (!ack_en) begin
      e_err = 1; e_rb = 1; e_len = AS + 16*C + AT;
    end else if (resp[2] != 8'h5A) begin
      e_err = 2; e_rb = 3;
      e_len = AS + 2*(15*C + 3 + BG) + ack_d[0] + ack_d[1] + 16*C;
    end else begin
      for (int k = 0; k < 4; k++) lnk += 15*C + 3 + BG + ack_d[k];
      e_err = 0; e_rb = 5; e_len = AS + lnk + 16*C + AH;
      exp_buttons = {resp[4], resp[3]};
      exp_id      = resp[1];
    end
    tol = 2 * e_rb;

    @(negedge clk);
    base_valid = n_valid; base_fall = n_att_fall;
    start = 1'b1;
    @(posedge clk); #1;
    s_cyc = cyc;
    check({tag, "_att_low"}, att, 0);
    check({tag, "_busy_hi"}, busy, 1);

    seen = 0; v_cyc = 0; v_err = 0; v_id = 0; v_btn = 0; v_att = 0; v_rb = 0;
    for (int i = 1; i < 6000; i++) begin
      @(negedge clk);
      start = (i == poke);
      if (valid === 1'b1) begin
        seen = 1; v_cyc = cyc; v_err = err; v_id = ctrl_id; v_btn = buttons;
        v_att = att; v_rb = rb;
        break;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_valid_timeout"}, 0, 1);
      return;
    end

    check({tag, "_err"}, v_err, e_err);
    check({tag, "_ctrl_id"}, v_id, exp_id);
    check({tag, "_buttons"}, v_btn, exp_buttons);
    check({tag, "_att_at_valid"}, v_att, 1);
    check({tag, "_bytes_clocked"}, v_rb, e_rb);
    got_len = v_cyc - s_cyc;
    check({tag, "_length"}, ((got_len >= e_len - tol) && (got_len <= e_len + tol)) ? e_len : got_len,
          e_len);
    for (int k = 0; k < 5; k++) begin
      if (k < e_rb) begin
        e_cmd = (k == 0) ? 8'h01 : (k == 1) ? 8'h42 : 8'h00;
        check($sformatf("%s_cmd%0d", tag, k), cmd_rx[k], e_cmd);
      end
    end

    @(negedge clk);
    check({tag, "_valid_1cyc"}, valid, 0);
    check({tag, "_busy_lo"}, busy, 0);
    check({tag, "_n_valid"}, n_valid, base_valid + 1);
    check({tag, "_n_att_fall"}, n_att_fall, base_fall + 1);
  endtask

  initial begin
    int  hit, falls;
    rst = 1'b1; start = 1'b0; ack_en = 1'b1; ack_len = 3;
    set_resp(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF);
    for (int k = 0; k < 4; k++) ack_d[k] = C;
    repeat (3) @(posedge clk);
    #1;
    check("rst_att", att, 1);
    check("rst_psx_clk", psx_clk, 1);
    check("rst_cmd", cmd, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_ctrl_id", ctrl_id, 8'h00);
    check("rst_buttons", buttons, 16'hFFFF);
    @(negedge clk) rst = 1'b0;

    ack_en = 1'b0;
    run_poll("noack", 0);
    check("noack_buttons_ffff", buttons, 16'hFFFF);

    ack_en = 1'b1;
    run_poll("ok", 0);
    check("ok_buttons_fffe", buttons, 16'hFFFE);
    check("ok_id_41", ctrl_id, 8'h41);

    set_resp(8'hFF, 8'h41, 8'h00, 8'hFE, 8'hFF);
    run_poll("notready", 0);

    set_resp(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF);
    run_poll("midstart", 300);
    falls = n_att_fall;
    repeat (20) @(negedge clk);
    check("midstart_no_requeue", n_att_fall, falls);

    // Reset during byte3
    for (int k = 0; k < 4; k++) ack_d[k] = C + 5;
    ack_len = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (rb == 3 && rbit >= 3) begin hit = 1; break; end
    end
    check("rst_reach_byte3", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_att", att, 1);
    check("midrst_psx_clk", psx_clk, 1);
    check("midrst_cmd", cmd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_buttons", buttons, 16'hFFFF);
    @(negedge clk) rst = 1'b0;
    exp_buttons = 16'hFFFF; exp_id = 8'h00;
    run_poll("after_rst", 0);

    set_resp(8'hFF, 8'h41, 8'h5A, 8'hFD, 8'hFF);
    run_poll("b2b", 0);
    check("b2b_buttons_fffd", buttons, 16'hFFFD);

    for (int t = 0; t < 10; t++) begin
      logic [7:0] b2;
      b2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h5A;
      set_resp(8'($urandom), 8'($urandom), b2, 8'($urandom), 8'($urandom));
      ack_en = ($urandom_range(0, 5) != 0);
      run_poll($sformatf("rnd%0d", t), ($urandom_range(0, 2) == 0) ? $urandom_range(20, 400) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
